// File: rtl/fc_pkg.sv
// Shared state type and width helpers for the sequential fully-connected neuron.
package fc_pkg;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} fc_state_t;

   // The adder tree grows by one bit per level; the accumulator by clog2 of the input count.
   function automatic int sum_width(input int width, input int lanes);
      return 2*width + $clog2(lanes);
   endfunction

   function automatic int out_width(input int width, input int n_in);
      return 2*width + $clog2(n_in);
   endfunction

   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

   function automatic bit cfg_ok(input int n_in, input int lanes);
      return (lanes >= 1) && (lanes <= 32) && ((lanes & (lanes - 1)) == 0) &&
             (n_in >= lanes) && ((n_in % lanes) == 0);
   endfunction

endpackage

// File: rtl/fc_mac_lanes.sv
// LANES signed multipliers feeding a balanced adder tree; purely combinational.
module fc_mac_lanes
   import fc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   localparam int SW = sum_width(WIDTH, LANES)
) (
   input  logic [WIDTH*LANES-1:0] x,
   input  logic [WIDTH*LANES-1:0] w,
   output logic signed [SW-1:0]   sum
);

   localparam int LVLS = $clog2(LANES);

   // Level 0 holds the sign-extended products; each further level halves the node count.
   for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
      logic signed [SW-1:0] v [LANES >> l];
      if (l == 0) begin : g_leaf
         for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic signed [WIDTH-1:0]   xs;
            logic signed [WIDTH-1:0]   ws;
            logic signed [2*WIDTH-1:0] prod;
            assign xs   = x[k*WIDTH +: WIDTH];
            assign ws   = w[k*WIDTH +: WIDTH];
            assign prod = xs * ws;
            assign v[k] = SW'(prod);
         end
      end else begin : g_add
         for (genvar n = 0; n < (LANES >> l); n++) begin : g_node
            assign v[n] = g_lvl[l-1].v[2*n] + g_lvl[l-1].v[2*n+1];
         end
      end
   end

   assign sum = g_lvl[LVLS].v[0];

endmodule

// File: rtl/fc_neuron_seq.sv
// Time-multiplexed neuron: LANES MACs per beat, registered accumulator, ReLU output.
// Define FC_BIAS_EN to add a signed bias, sampled on the last beat, before the ReLU.
module fc_neuron_seq
   import fc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IN    = 128,
   parameter int LANES = 4,
   localparam int OUT_W = out_width(WIDTH, IN)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH*LANES-1:0] x,
   input  logic [WIDTH*LANES-1:0] w,
   input  logic [OUT_W-1:0]       bias,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       z
);

   localparam int SW    = sum_width(WIDTH, LANES);
   localparam int BEATS = IN / LANES;
   localparam int CW    = cnt_width(BEATS);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   if (!cfg_ok(IN, LANES)) begin : g_cfg_err
      $error("fc_neuron_seq: IN must be a multiple of LANES and LANES a power of two in 1..32");
   end

   fc_state_t            state, state_nxt;
   logic [CW-1:0]        beat_cnt;
   logic signed [SW-1:0] mac_sum, s1_sum;
   logic                 s1_valid;
   logic signed [OUT_W-1:0] acc, acc_sum, drain_sum;
   logic                 accept, last_beat;

   fc_mac_lanes #(.WIDTH(WIDTH), .LANES(LANES)) u_mac (
      .x   (x),
      .w   (w),
      .sum (mac_sum)
   );

   assign in_ready  = (state == RUN) && !rst;
   assign accept    = in_valid && in_ready;
   assign last_beat = accept && (beat_cnt == LAST_BEAT);
   assign acc_sum   = s1_valid ? acc + OUT_W'(s1_sum) : acc;

`ifdef FC_BIAS_EN
   logic signed [OUT_W-1:0] bias_q;

   always_ff @(posedge clk) begin
      if (rst)
         bias_q <= '0;
      else if (last_beat)
         bias_q <= bias;
   end

   assign drain_sum = acc_sum + bias_q;
`else
   logic unused_bias;
   assign unused_bias = ^bias;
   assign drain_sum   = acc_sum;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (last_beat) state_nxt = DRAIN;
         DRAIN:   state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Stage 1 captures the lane sum; the accumulator absorbs it one cycle later, even across bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt  <= '0;
         s1_sum    <= '0;
         s1_valid  <= 1'b0;
         acc       <= '0;
         out_valid <= 1'b0;
         z         <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_sum   <= mac_sum;
            beat_cnt <= beat_cnt + 1'b1;
         end
         case (state)
            RUN:   acc <= acc_sum;
            DRAIN: begin
               acc       <= drain_sum;
               z         <= drain_sum[OUT_W-1] ? '0 : drain_sum;
               out_valid <= 1'b1;
            end
            DONE:  if (out_ready) begin
               acc       <= '0;
               beat_cnt  <= '0;
               out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
